// File: rtl/cube_scan_driver.sv
// rtl/cube_scan_driver.sv - layer-multiplexed cube scan driver with double-buffered frames
//
// Shows a SIDE x SIDE x SIDE cell cube one layer at a time. Each layer runs
// through SHIFT, LATCH, ON and BLANK:
//   SHIFT  serialise the layer's SIDE^2 column bits, highest column first
//   LATCH  pulse the latch strobe on the external column registers
//   ON     drive the layer for part of a fixed dwell window, set by Brightness
//   BLANK  hold every layer off before the next layer's columns change
// Frames are captured into a back buffer and only copied into the displayed
// front buffer at a frame boundary, so a layer never shows a mix of two frames.
//
// Ports:
//   Clk, Reset   system clock, asynchronous active-high reset
//   Cells        flat cell vector, cell (x,y,z) at bit z*SIDE^2 + y*SIDE + x
//   FrameValid   source has a frame on Cells; held until FrameAck
//   FrameAck     one-cycle pulse, frame taken into the back buffer
//   Brightness   on-time in steps of DWELL_CYCLES / 2^BRIGHT_W (0 = one step)
//   Enable       scan enable; dropping it finishes the current layer first
//   SerData      column serial data
//   SerClk       column shift clock
//   SerLatch     column register latch strobe
//   LayerEn      one-hot layer drive
//   LayerIdx     layer currently being shifted or displayed
//   FrameDone    one-cycle pulse after the last layer's blank completes

module cube_scan_driver #(
    parameter int SIDE         = 8,
    parameter int CLK_DIV      = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int DWELL_CYCLES = 4096,
    parameter int BRIGHT_W     = 4,
    localparam int IDX_W       = (SIDE > 1) ? $clog2(SIDE) : 1
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [SIDE*SIDE*SIDE-1:0]   Cells,
    input  logic                        FrameValid,
    output logic                        FrameAck,
    input  logic [BRIGHT_W-1:0]         Brightness,
    input  logic                        Enable,
    output logic                        SerData,
    output logic                        SerClk,
    output logic                        SerLatch,
    output logic [SIDE-1:0]             LayerEn,
    output logic [IDX_W-1:0]            LayerIdx,
    output logic                        FrameDone
);

    localparam int CELLS   = SIDE * SIDE * SIDE;
    localparam int COLS    = SIDE * SIDE;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    // Length of one brightness step inside the dwell window.
    localparam int STEP    = DWELL_CYCLES / (1 << BRIGHT_W);
    // One shared cycle counter serves every timed state, so it must hold the
    // longest of them.
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES)
                             ? ((DWELL_CYCLES > CLK_DIV) ? DWELL_CYCLES : CLK_DIV)
                             : ((BLANK_CYCLES > CLK_DIV) ? BLANK_CYCLES : CLK_DIV);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_ON,
        S_BLANK
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic               phase;          // current SerClk level while shifting
    logic [COL_W-1:0]   bit_idx;        // column being shifted, counts down
    logic [IDX_W-1:0]   z;
    logic [CNT_W-1:0]   on_limit;       // dwell cycles with the layer driven

    logic [CELLS-1:0]   front;
    logic [CELLS-1:0]   back;
    logic               pending;
    logic               frame_ack;
    logic               frame_done;

    logic [COLS-1:0]    layer_bits;

    logic               div_done;
    logic               shift_done;
    logic               latch_done;
    logic               dwell_done;
    logic               blank_done;
    logic               frame_end;
    logic               capture;
    logic               swap;

    assign div_done   = (cnt == CNT_W'(CLK_DIV - 1));
    assign shift_done = (state == S_SHIFT) && phase && div_done && (bit_idx == '0);
    assign latch_done = (state == S_LATCH) && div_done;
    assign dwell_done = (state == S_ON) && (cnt == CNT_W'(DWELL_CYCLES - 1));
    assign blank_done = (state == S_BLANK) && (cnt == CNT_W'(BLANK_CYCLES - 1));
    assign frame_end  = blank_done && (z == IDX_W'(SIDE - 1));

    // Capture is refused while a frame is pending, which also covers the
    // capture-and-swap cycle: the swap takes the old back buffer and the
    // source keeps FrameValid up until a later cycle acknowledges it.
    assign capture    = FrameValid && !pending;
    assign swap       = pending && (((state == S_IDLE) && Enable) || frame_end);

    assign layer_bits = front[z*COLS +: COLS];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Enable)     state_nxt = S_SHIFT;
            S_SHIFT: if (shift_done) state_nxt = S_LATCH;
            S_LATCH: if (latch_done) state_nxt = S_ON;
            S_ON:    if (dwell_done) state_nxt = S_BLANK;
            S_BLANK: if (blank_done) state_nxt = Enable ? S_SHIFT : S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        SerClk   = 1'b0;
        SerData  = 1'b0;
        SerLatch = 1'b0;
        LayerEn  = '0;
        case (state)
            S_SHIFT: begin
                SerClk  = phase;
                // bit_idx only moves on the high->low transition, so data is
                // stable for the whole bit and changes with the clock low.
                SerData = layer_bits[bit_idx];
            end
            S_LATCH: SerLatch = 1'b1;
            S_ON: begin
                if (cnt < on_limit) begin
                    LayerEn[z] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign LayerIdx  = z;
    assign FrameAck  = frame_ack;
    assign FrameDone = frame_done;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            phase    <= 1'b0;
            bit_idx  <= COL_W'(COLS - 1);
            z        <= '0;
            on_limit <= '0;
        end else begin
            // Every state starts its count from zero; in SHIFT the counter
            // restarts on each SerClk half-period.
            if ((state_nxt != state) || (state == S_IDLE)) begin
                cnt <= '0;
            end else if ((state == S_SHIFT) && div_done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state != S_SHIFT) begin
                phase <= 1'b0;
            end else if (div_done) begin
                phase <= ~phase;
            end

            if (state != S_SHIFT) begin
                bit_idx <= COL_W'(COLS - 1);
            end else if (div_done && phase) begin
                bit_idx <= bit_idx - COL_W'(1);
            end

            // Dropping Enable always restarts the next scan at layer 0.
            if (blank_done) begin
                if (!Enable || (z == IDX_W'(SIDE - 1))) begin
                    z <= '0;
                end else begin
                    z <= z + IDX_W'(1);
                end
            end

            // Brightness is frozen for the whole on-window of a layer.
            if (latch_done) begin
                on_limit <= CNT_W'((int'(Brightness) + 1) * STEP);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame buffers and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            front      <= '0;
            back       <= '0;
            pending    <= 1'b0;
            frame_ack  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (capture) begin
                back <= Cells;
            end
            if (swap) begin
                front <= back;
            end

            if (swap) begin
                pending <= 1'b0;
            end else if (capture) begin
                pending <= 1'b1;
            end

            frame_ack  <= capture;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_cube_scan_driver.sv
// tb/tb_cube_scan_driver.sv - directed table-driven bench for cube_scan_driver

module tb_cube_scan_driver;

    localparam int SIDE         = 2;
    localparam int CLK_DIV      = 1;
    localparam int BLANK_CYCLES = 2;
    localparam int DWELL_CYCLES = 16;
    localparam int BRIGHT_W     = 2;

    // One layer: 8 shift + 1 latch + 16 on + 2 blank cycles.
    localparam int LAYER_CYC    = 27;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Cells = 8'h00;
    logic       FrameValid = 1'b0;
    logic       FrameAck;
    logic [1:0] Brightness = 2'b00;
    logic       Enable = 1'b0;
    logic       SerData;
    logic       SerClk;
    logic       SerLatch;
    logic [1:0] LayerEn;
    logic [0:0] LayerIdx;
    logic       FrameDone;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] bits;          // expected column bits, bit 3 shifted first
        logic [1:0] bright;        // Brightness driven before the on-window
        logic [1:0] bright_mid;    // Brightness driven in the middle of it
        int         on_cycles;
        logic       idx;
        logic       done_at_start; // FrameDone expected in the first cycle
        int         ack_at;        // cycle FrameAck is expected, -1 none
        int         fv_on;         // cycle to raise FrameValid with fv_cells
        logic [7:0] fv_cells;
        int         fv_off;        // cycle to drop FrameValid
        int         cells_at;      // cycle to change Cells to cells_val
        logic [7:0] cells_val;
        int         en_off;        // cycle to drop Enable
    } layer_vec_t;

    layer_vec_t tbl [8];

    cube_scan_driver #(
        .SIDE         (SIDE),
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BRIGHT_W     (BRIGHT_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Cells      (Cells),
        .FrameValid (FrameValid),
        .FrameAck   (FrameAck),
        .Brightness (Brightness),
        .Enable     (Enable),
        .SerData    (SerData),
        .SerClk     (SerClk),
        .SerLatch   (SerLatch),
        .LayerEn    (LayerEn),
        .LayerIdx   (LayerIdx),
        .FrameDone  (FrameDone)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_layer_en"}, 32'(LayerEn), 0);
        chk({name, "_ser_clk"}, 32'(SerClk), 0);
        chk({name, "_ser_data"}, 32'(SerData), 0);
        chk({name, "_ser_latch"}, 32'(SerLatch), 0);
        chk({name, "_layer_idx"}, 32'(LayerIdx), 0);
        chk({name, "_frame_ack"}, 32'(FrameAck), 0);
        chk({name, "_frame_done"}, 32'(FrameDone), 0);
    endtask

    // Layer drive must never be multi-hot, nor on while shifting or latching.
    always @(negedge Clk) begin
        if (!Reset) begin
            checks++;
            if (($countones(LayerEn) > 1) || ((LayerEn != 2'b00) && (SerClk || SerLatch))) begin
                errors++;
                $display("FAIL layer_en_exclusive: actual LayerEn=%b SerClk=%b SerLatch=%b required at most one-hot and off while shifting/latching",
                         LayerEn, SerClk, SerLatch);
            end
        end
    end

    // Called on the first negedge of a layer's SHIFT; returns on the first
    // negedge after that layer's BLANK.
    task automatic run_layer(input int k, input layer_vec_t v);
        logic [1:0] exp_en;
        string      tag;
        for (int i = 0; i < LAYER_CYC; i++) begin
            tag = $sformatf("v%0d_z%0d_c%0d", k, v.idx, i);
            chk({tag, "_layer_idx"}, 32'(LayerIdx), 32'(v.idx));
            if (i < 8) begin
                chk({tag, "_ser_clk"}, 32'(SerClk), 32'(i % 2));
                chk({tag, "_ser_data"}, 32'(SerData), 32'(v.bits[3 - i/2]));
            end else begin
                chk({tag, "_ser_clk"}, 32'(SerClk), 0);
            end
            chk({tag, "_ser_latch"}, 32'(SerLatch), 32'(i == 8));
            exp_en = 2'b00;
            if ((i >= 9) && (i < 25) && ((i - 9) < v.on_cycles)) begin
                exp_en = v.idx ? 2'b10 : 2'b01;
            end
            chk({tag, "_layer_en"}, 32'(LayerEn), 32'(exp_en));
            chk({tag, "_frame_done"}, 32'(FrameDone), 32'((i == 0) ? v.done_at_start : 1'b0));
            chk({tag, "_frame_ack"}, 32'(FrameAck), 32'(i == v.ack_at));

            if (i == 8)          Brightness = v.bright;
            if (i == 16)         Brightness = v.bright_mid;
            if (i == v.fv_on)    begin FrameValid = 1'b1; Cells = v.fv_cells; end
            if (i == v.cells_at) Cells = v.cells_val;
            if (i == v.fv_off)   FrameValid = 1'b0;
            if (i == v.en_off)   Enable = 1'b0;
            @(negedge Clk);
        end
    endtask

    initial begin
        tbl[0] = '{bits:4'b0101, bright:2'd3, bright_mid:2'd0, on_cycles:16, idx:1'b0, done_at_start:1'b0,
                   ack_at:11, fv_on:10, fv_cells:8'h3C, fv_off:-1, cells_at:11, cells_val:8'hC3, en_off:-1};
        tbl[1] = '{bits:4'b1010, bright:2'd0, bright_mid:2'd3, on_cycles:4, idx:1'b1, done_at_start:1'b0,
                   ack_at:-1, fv_on:-1, fv_cells:8'h00, fv_off:-1, cells_at:-1, cells_val:8'h00, en_off:-1};
        tbl[2] = '{bits:4'b1100, bright:2'd1, bright_mid:2'd1, on_cycles:8, idx:1'b0, done_at_start:1'b1,
                   ack_at:1, fv_on:-1, fv_cells:8'h00, fv_off:1, cells_at:-1, cells_val:8'h00, en_off:-1};
        tbl[3] = '{bits:4'b0011, bright:2'd2, bright_mid:2'd0, on_cycles:12, idx:1'b1, done_at_start:1'b0,
                   ack_at:-1, fv_on:-1, fv_cells:8'h00, fv_off:-1, cells_at:-1, cells_val:8'h00, en_off:-1};
        tbl[4] = '{bits:4'b0011, bright:2'd3, bright_mid:2'd3, on_cycles:16, idx:1'b0, done_at_start:1'b1,
                   ack_at:-1, fv_on:-1, fv_cells:8'h00, fv_off:-1, cells_at:-1, cells_val:8'h00, en_off:-1};
        tbl[5] = '{bits:4'b1100, bright:2'd2, bright_mid:2'd2, on_cycles:12, idx:1'b1, done_at_start:1'b0,
                   ack_at:-1, fv_on:-1, fv_cells:8'h00, fv_off:-1, cells_at:-1, cells_val:8'h00, en_off:3};
        tbl[6] = '{bits:4'b0000, bright:2'd3, bright_mid:2'd3, on_cycles:16, idx:1'b0, done_at_start:1'b0,
                   ack_at:-1, fv_on:-1, fv_cells:8'h00, fv_off:-1, cells_at:-1, cells_val:8'h00, en_off:-1};
        tbl[7] = '{bits:4'b0000, bright:2'd0, bright_mid:2'd0, on_cycles:4, idx:1'b1, done_at_start:1'b0,
                   ack_at:-1, fv_on:-1, fv_cells:8'h00, fv_off:-1, cells_at:-1, cells_val:8'h00, en_off:3};

        // Reset state
        repeat (2) @(negedge Clk);
        chk_all_zero("in_reset");
        Reset = 1'b0;
        @(negedge Clk);
        chk_all_zero("idle_after_reset");

        // Load A5 while idle; ack follows one cycle later for one cycle
        FrameValid = 1'b1;
        Cells      = 8'hA5;
        @(negedge Clk);
        chk("first_ack", 32'(FrameAck), 1);
        FrameValid = 1'b0;
        Cells      = 8'h00;
        @(negedge Clk);
        chk("first_ack_single", 32'(FrameAck), 0);
        chk("idle_layer_en", 32'(LayerEn), 0);
        chk("idle_ser_clk", 32'(SerClk), 0);

        // Three passes: A5, then 3C, then C3 with Enable dropped in layer 1
        Enable = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < 6; k++) begin
            run_layer(k, tbl[k]);
        end
        chk("stop_frame_done", 32'(FrameDone), 1);
        chk("stop_layer_idx", 32'(LayerIdx), 0);
        chk("stop_layer_en", 32'(LayerEn), 0);
        chk("stop_frame_ack", 32'(FrameAck), 0);
        for (int n = 0; n < 4; n++) begin
            @(negedge Clk);
            chk($sformatf("idle%0d_frame_done", n), 32'(FrameDone), 0);
            chk($sformatf("idle%0d_ser_clk", n), 32'(SerClk), 0);
            chk($sformatf("idle%0d_ser_latch", n), 32'(SerLatch), 0);
            chk($sformatf("idle%0d_layer_en", n), 32'(LayerEn), 0);
            chk($sformatf("idle%0d_layer_idx", n), 32'(LayerIdx), 0);
        end

        // Asynchronous reset in the middle of layer 0's on-window
        Brightness = 2'd3;
        Enable     = 1'b1;
        @(negedge Clk);
        repeat (12) @(negedge Clk);
        chk("mid_on_layer_en", 32'(LayerEn), 32'(2'b01));
        #2;
        Reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge Clk);
        chk_all_zero("held_reset");
        Reset = 1'b0;
        @(negedge Clk);

        // Scan restarts from layer 0 with the cleared frame
        run_layer(6, tbl[6]);
        run_layer(7, tbl[7]);
        chk("cleared_frame_done", 32'(FrameDone), 1);
        chk("cleared_layer_idx", 32'(LayerIdx), 0);
        chk("cleared_layer_en", 32'(LayerEn), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
